// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI peripheral register-file responder
//
// Purpose:
//   SPI slave for the on-board serial bus. It models a board peripheral as a
//   small register file. SEN, SCLK and MOSI are over-sampled on clk through
//   2-FF synchronisers. SCLK is CPOL=0: MOSI is sampled on rising edges and
//   MISO is shifted on falling edges.
//   Frame layout, MSB first: R/W bit (1 = read), ADDR_W address bits, then
//   DATA_W data bits.
//
// Optional feature:
//   SPI_RESP_ERRCNT_EN - when defined, err_cnt counts aborted frames and
//   saturates at 8'hFF. When undefined, err_cnt is tied to 0.
//
// Ports:
//   clk        in   system clock (SCLK <= clk/8)
//   reset_n    in   asynchronous active-low reset
//   sen        in   chip enable, active low (asynchronous)
//   sclk       in   SPI clock (asynchronous)
//   mosi       in   serial data in (asynchronous)
//   miso       out  serial data out
//   miso_oe    out  high while selected and in the read data phase
//   wr_stb     out  one-cycle pulse on a committed write
//   wr_addr    out  address of the last committed write
//   wr_data    out  data of the last committed write
//   regs_flat  out  register k at [k*DATA_W +: DATA_W]
//   err_cnt    out  aborted-frame count
module spi_responder #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sen,
  input  logic                       sclk,
  input  logic                       mosi,
  output logic                       miso,
  output logic                       miso_oe,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [7:0]                 err_cnt
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int BC_W      = $clog2(FRAME_LEN + 1);
  localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [BC_W-1:0]   HDR_LAST   = BC_W'(ADDR_W);
  localparam logic [BC_W-1:0]   DATA_LAST  = BC_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_DONE
  } state_t;

  // Synchronisers. The SEN chain resets to the deselected level so that
  // leaving reset never looks like a falling chip enable.
  logic sen_m_q, sen_s_q, sen_p_q;
  logic sclk_m_q, sclk_s_q, sclk_p_q;
  logic mosi_m_q, mosi_s_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sen_m_q  <= 1'b1;
      sen_s_q  <= 1'b1;
      sen_p_q  <= 1'b1;
      sclk_m_q <= 1'b0;
      sclk_s_q <= 1'b0;
      sclk_p_q <= 1'b0;
      mosi_m_q <= 1'b0;
      mosi_s_q <= 1'b0;
    end else begin
      sen_m_q  <= sen;
      sen_s_q  <= sen_m_q;
      sen_p_q  <= sen_s_q;
      sclk_m_q <= sclk;
      sclk_s_q <= sclk_m_q;
      sclk_p_q <= sclk_s_q;
      mosi_m_q <= mosi;
      mosi_s_q <= mosi_m_q;
    end
  end

  logic sen_fall, sen_rise, sclk_rise, sclk_fall;
  assign sen_fall  = sen_p_q & ~sen_s_q;
  assign sen_rise  = ~sen_p_q & sen_s_q;
  // SCLK edges only count while the chip is selected.
  assign sclk_rise = ~sen_s_q & sclk_s_q & ~sclk_p_q;
  assign sclk_fall = ~sen_s_q & ~sclk_s_q & sclk_p_q;

  state_t                      state_q, state_d;
  logic [BC_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]           hdr_q, hdr_d;
  logic                        rw_q, rw_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [DATA_W-2:0]           data_q, data_d;
  logic [DATA_W-1:0]           shout_q, shout_d;
  logic                        miso_q, miso_d;
  logic [NUM_REGS*DATA_W-1:0]  regs_q, regs_d;
  logic                        wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]           wr_data_q, wr_data_d;
  logic                        abort;

  logic [ADDR_W:0]             hdr_full;
  logic [ADDR_W-1:0]           hdr_addr;
  logic [IDX_W-1:0]            hdr_idx;
  logic [IDX_W-1:0]            addr_idx;
  logic [DATA_W-1:0]           data_full;
  logic [BC_W-1:0]             bit_cnt_inc;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    hdr_d     = hdr_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    data_d    = data_q;
    shout_d   = shout_q;
    miso_d    = miso_q;
    regs_d    = regs_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    abort     = 1'b0;

    // Header/data words as they stand including the bit sampled this cycle.
    hdr_full    = {hdr_q, mosi_s_q};
    hdr_addr    = hdr_full[ADDR_W-1:0];
    hdr_idx     = hdr_addr[IDX_W-1:0];
    addr_idx    = addr_q[IDX_W-1:0];
    data_full   = {data_q, mosi_s_q};
    bit_cnt_inc = (bit_cnt_q == {BC_W{1'b1}}) ? bit_cnt_q : bit_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (sen_fall) begin
          state_d   = ST_HEADER;
          bit_cnt_d = '0;
          hdr_d     = '0;
          data_d    = '0;
        end
      end

      ST_HEADER: begin
        if (sen_rise) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          hdr_d     = hdr_full[ADDR_W-1:0];
          bit_cnt_d = bit_cnt_inc;
          if (bit_cnt_q == HDR_LAST) begin
            // Last header bit: latch the command and preload read data so
            // the first data bit is ready for the very next SCLK fall.
            state_d = ST_DATA;
            rw_d    = hdr_full[ADDR_W];
            addr_d  = hdr_addr;
            miso_d  = 1'b0;
            if (({1'b0, hdr_addr} < NUM_REGS_A) && hdr_full[ADDR_W]) begin
              shout_d = regs_q[hdr_idx*DATA_W +: DATA_W];
            end else begin
              shout_d = '0;
            end
          end
        end
      end

      ST_DATA: begin
        if (sen_rise) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_inc;
            if (!rw_q) begin
              data_d = data_full[DATA_W-2:0];
            end
            if (bit_cnt_q == DATA_LAST) begin
              state_d = ST_DONE;
              if (!rw_q && ({1'b0, addr_q} < NUM_REGS_A)) begin
                regs_d[addr_idx*DATA_W +: DATA_W] = data_full;
                wr_stb_d  = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = data_full;
              end
            end
          end
          if (sclk_fall && rw_q) begin
            miso_d  = shout_q[DATA_W-1];
            shout_d = {shout_q[DATA_W-2:0], 1'b0};
          end
        end
      end

      ST_DONE: begin
        if (sen_rise) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      hdr_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      shout_q   <= '0;
      miso_q    <= 1'b0;
      regs_q    <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      hdr_q     <= hdr_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      shout_q   <= shout_d;
      miso_q    <= miso_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef SPI_RESP_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (abort && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign err_cnt      = 8'h00;
`endif

  // Combinational gating gives zero outputs in the same cycle as reset.
  assign miso_oe   = (state_q == ST_DATA) && rw_q;
  assign miso      = miso_oe & miso_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign regs_flat = regs_q;

endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - self-checking bench for spi_responder
module tb_spi_responder;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         sen = 1'b1;
  logic         sclk = 1'b0;
  logic         mosi = 1'b0;
  logic         miso, miso_oe, wr_stb;
  logic [6:0]   wr_addr;
  logic [15:0]  wr_data;
  logic [255:0] regs_flat;
  logic [7:0]   err_cnt;

  spi_responder #(.DATA_W(16), .ADDR_W(7), .NUM_REGS(16)) dut (
    .clk(clk), .reset_n(reset_n), .sen(sen), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .regs_flat(regs_flat), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int stb_cnt = 0;
  int err_exp = 0;
  logic [15:0] mregs [16];

  always @(negedge clk) if (wr_stb === 1'b1) stb_cnt++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int k = 0; k < 16; k++) f[k*16 +: 16] = mregs[k];
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clocks out the first n bits of a frame at SCLK = clk/8 and captures MISO
  // just before every data-phase rising edge.
  task automatic send_bits(input logic [23:0] fr, input int n,
                           output logic [15:0] rd, output int oe_cnt);
    rd = '0;
    oe_cnt = 0;
    for (int i = 0; i < n; i++) begin
      mosi = fr[23-i];
      tick(4);
      if (i >= 8 && i < 24) begin
        rd[23-i] = miso;
        if (miso_oe === 1'b1) oe_cnt++;
      end else if (miso_oe === 1'b1) begin
        oe_cnt++;
      end
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input bit rw, input logic [6:0] addr, input logic [15:0] data,
                       input int n, input int extra,
                       output logic [15:0] rd, output int oe_cnt, output logic oe_after);
    sen = 1'b0;
    tick(4);
    send_bits({rw, addr, data}, n, rd, oe_cnt);
    tick(4);
    oe_after = miso_oe;
    for (int e = 0; e < extra; e++) begin
      mosi = e[0];
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
      tick(4);
    end
    sen = 1'b1;
    mosi = 1'b0;
    tick(6);
  endtask

  typedef struct {
    bit          rw;
    logic [6:0]  addr;
    logic [15:0] data;
    int          extra;
    int          exp_stb;
    logic [15:0] exp_rd;
  } vec_t;

  // Applies one full frame, checks it against the expected values and keeps
  // the register model in step with what a correct peripheral would do.
  task automatic run_vec(input string tag, input vec_t v);
    logic [15:0] rd;
    int oe_cnt, stb0;
    logic oe_after;
    stb0 = stb_cnt;
    frame(v.rw, v.addr, v.data, 24, v.extra, rd, oe_cnt, oe_after);
    if (!v.rw && v.addr < 16) mregs[v.addr[3:0]] = v.data;
    check({tag, " wr_stb count"}, 256'(stb_cnt - stb0), 256'(v.exp_stb));
    check({tag, " miso_oe bits"}, 256'(oe_cnt), v.rw ? 256'(16) : 256'(0));
    check({tag, " miso_oe after frame"}, 256'(oe_after), 256'(0));
    if (v.rw) check({tag, " read data"}, 256'(rd), 256'(v.exp_rd));
    if (v.exp_stb != 0) begin
      check({tag, " wr_addr"}, 256'(wr_addr), 256'(v.addr));
      check({tag, " wr_data"}, 256'(wr_data), 256'(v.data));
    end
    check({tag, " regs_flat"}, regs_flat, model_flat());
  endtask

  initial begin
    vec_t tbl[6];
    logic [15:0] rd;
    int oe_cnt, stb0;
    logic oe_after;
    logic [255:0] flat0;

    for (int k = 0; k < 16; k++) mregs[k] = '0;

    tbl[0] = '{1'b0, 7'd3,  16'hA5C3, 0,  1, 16'h0000};
    tbl[1] = '{1'b1, 7'd3,  16'h0000, 0,  0, 16'hA5C3};
    tbl[2] = '{1'b0, 7'd20, 16'h1234, 0,  0, 16'h0000};
    tbl[3] = '{1'b1, 7'd20, 16'hFFFF, 0,  0, 16'h0000};
    tbl[4] = '{1'b0, 7'd2,  16'hFFFF, 30, 1, 16'h0000};
    tbl[5] = '{1'b1, 7'd2,  16'h0000, 0,  0, 16'hFFFF};

    tick(3);
    check("reset miso", 256'(miso), 256'(0));
    check("reset miso_oe", 256'(miso_oe), 256'(0));
    check("reset wr_stb", 256'(wr_stb), 256'(0));
    check("reset wr_addr", 256'(wr_addr), 256'(0));
    check("reset wr_data", 256'(wr_data), 256'(0));
    check("reset regs_flat", regs_flat, 256'(0));
    check("reset err_cnt", 256'(err_cnt), 256'(0));
    reset_n = 1'b1;
    tick(4);

    for (int t = 0; t < 6; t++) run_vec($sformatf("tbl%0d", t), tbl[t]);
    check("reg3 slice", 256'(regs_flat[63:48]), 256'(16'hA5C3));

    // Abort: SEN raised after 12 rises of a write to addr 1.
    stb0 = stb_cnt;
    frame(1'b0, 7'd1, 16'h5A5A, 12, 0, rd, oe_cnt, oe_after);
`ifdef SPI_RESP_ERRCNT_EN
    err_exp++;
`endif
    check("abort wr_stb", 256'(stb_cnt - stb0), 256'(0));
    check("abort regs_flat", regs_flat, model_flat());
    check("abort err_cnt", 256'(err_cnt), 256'(err_exp));

    // One-cycle SEN glitch.
    stb0 = stb_cnt;
    flat0 = regs_flat;
    sen = 1'b0;
    tick(1);
    sen = 1'b1;
    tick(8);
`ifdef SPI_RESP_ERRCNT_EN
    err_exp++;
`endif
    check("glitch wr_stb", 256'(stb_cnt - stb0), 256'(0));
    check("glitch regs_flat", regs_flat, flat0);
    check("glitch err_cnt", 256'(err_cnt), 256'(err_exp));
    run_vec("post-glitch read", '{1'b1, 7'd3, 16'h0000, 0, 0, 16'hA5C3});

    // Reset in the data phase of a read.
    sen = 1'b0;
    tick(4);
    send_bits({1'b1, 7'd3, 16'h0000}, 12, rd, oe_cnt);
    tick(2);
    check("mid-read miso_oe", 256'(miso_oe), 256'(1));
    reset_n = 1'b0;
    #1;
    check("reset mid-read miso", 256'(miso), 256'(0));
    check("reset mid-read miso_oe", 256'(miso_oe), 256'(0));
    check("reset mid-read regs_flat", regs_flat, 256'(0));
    for (int k = 0; k < 16; k++) mregs[k] = '0;
    err_exp = 0;
    sen = 1'b1;
    sclk = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(4);
    check("post-reset err_cnt", 256'(err_cnt), 256'(0));
    run_vec("post-reset write", '{1'b0, 7'd5, 16'hBEEF, 0, 1, 16'h0000});
    run_vec("post-reset read", '{1'b1, 7'd5, 16'h0000, 0, 0, 16'hBEEF});

    // Random frames against the register model.
    for (int r = 0; r < 40; r++) begin
      vec_t v;
      v.rw    = 1'($urandom_range(0, 1));
      v.addr  = 7'($urandom_range(0, 23));
      v.data  = 16'($urandom);
      v.extra = int'($urandom_range(0, 3));
      v.exp_stb = (!v.rw && v.addr < 16) ? 1 : 0;
      v.exp_rd  = (v.addr < 16) ? mregs[v.addr[3:0]] : 16'h0000;
      run_vec($sformatf("rnd%0d", r), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
